// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the GPR hazard scoreboard: counter widths,
// Tnew/Tuse encodings and the hardwired zero register index.
package cpu_pkg;

  localparam int NREG         = 32;
  localparam int CNT_W        = 2;
  localparam int MAX_INFLIGHT = 3;
  localparam int INF_W        = 2;

  localparam logic [CNT_W-1:0] TNEW_ALU    = 2'd1;
  localparam logic [CNT_W-1:0] TNEW_LOAD   = 2'd2;
  localparam logic [CNT_W-1:0] TUSE_BRANCH = 2'd0;
  localparam logic [CNT_W-1:0] TUSE_ALU    = 2'd1;
  localparam logic [CNT_W-1:0] TUSE_STORE  = 2'd2;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_entry.sv
// One GPR scoreboard entry: outstanding-writer count and ready countdown,
// with flush > issue/retire priority and overflow/underflow flags.
module sb_entry
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             issue,
  input  logic             retire,
  input  logic [CNT_W-1:0] tnew,
  output logic [INF_W-1:0] inflight,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  logic [INF_W-1:0] r_inflight;
  logic [CNT_W-1:0] r_cnt;
  logic [INF_W-1:0] w_inf_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_inf_nxt = r_inflight;
    w_cnt_nxt = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    ovf       = 1'b0;
    unf       = 1'b0;
    if (flush) begin
      w_inf_nxt = '0;
      w_cnt_nxt = '0;
    end else if (issue && retire) begin
      w_cnt_nxt = tnew;
    end else if (issue) begin
      // the newest writer defines readiness, even when the count saturates
      w_cnt_nxt = tnew;
      if (r_inflight == INF_W'(MAX_INFLIGHT)) ovf = 1'b1;
      else w_inf_nxt = r_inflight + INF_W'(1);
    end else if (retire) begin
      if (r_inflight == '0) begin
        unf = 1'b1;
      end else begin
        w_inf_nxt = r_inflight - INF_W'(1);
        if (r_inflight == INF_W'(1)) w_cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inflight <= '0;
      r_cnt      <= '0;
    end else begin
      r_inflight <= w_inf_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  assign inflight = r_inflight;
  assign cnt      = r_cnt;

endmodule

// File: rtl/grf_scoreboard.sv
// GPR hazard scoreboard beside the D stage: compares in-flight writer
// readiness against operand Tuse and raises stall; tracks sticky errors.
module grf_scoreboard
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [4:0]       issue_rd,
  input  logic [CNT_W-1:0] issue_tnew,
  input  logic             use_rs,
  input  logic [4:0]       rs,
  input  logic [CNT_W-1:0] rs_tuse,
  input  logic             use_rt,
  input  logic [4:0]       rt,
  input  logic [CNT_W-1:0] rt_tuse,
  input  logic             wb_we,
  input  logic [4:0]       wb_a3,
  input  logic             flush,
  output logic             stall,
  output logic [NREG-1:0]  busy_vec,
  output logic             err
);

  logic [INF_W-1:0] w_inflight [NREG];
  logic [CNT_W-1:0] w_cnt      [NREG];
  logic [NREG-1:0]  w_ovf;
  logic [NREG-1:0]  w_unf;
  logic             w_issue_fire;
  logic             w_retire;
  logic             w_rs_blk;
  logic             w_rt_blk;
  logic             r_err;

  assign w_issue_fire = issue_valid && !stall && issue_we &&
                        (issue_rd != REG_ZERO) && !flush;
  assign w_retire     = wb_we && (wb_a3 != REG_ZERO);

  for (genvar i = 0; i < NREG; i++) begin : g_entry
    if (i == 0) begin : g_zero
      assign w_inflight[i] = '0;
      assign w_cnt[i]      = '0;
      assign w_ovf[i]      = 1'b0;
      assign w_unf[i]      = 1'b0;
    end else begin : g_reg
      sb_entry u_entry (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .issue    (w_issue_fire && (issue_rd == 5'(i))),
        .retire   (w_retire && (wb_a3 == 5'(i))),
        .tnew     (issue_tnew),
        .inflight (w_inflight[i]),
        .cnt      (w_cnt[i]),
        .ovf      (w_ovf[i]),
        .unf      (w_unf[i])
      );
    end
    assign busy_vec[i] = (w_inflight[i] != '0);
  end

  // cnt==0 is covered by write-through/forwarding, so only cnt>Tuse blocks
  assign w_rs_blk = use_rs && (rs != REG_ZERO) && (w_inflight[rs] != '0) &&
                    (w_cnt[rs] > rs_tuse);
  assign w_rt_blk = use_rt && (rt != REG_ZERO) && (w_inflight[rt] != '0) &&
                    (w_cnt[rt] > rt_tuse);
  assign stall    = !reset && issue_valid && (w_rs_blk || w_rt_blk);

  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else if ((|w_ovf) || (|w_unf)) r_err <= 1'b1;
  end

  assign err = r_err;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed, table-driven bench for grf_scoreboard: one row per clock cycle
// with hand-computed stall (before the edge) and busy_vec/err (after it).
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd;
  logic [1:0]  issue_tnew;
  logic        use_rs, use_rt;
  logic [4:0]  rs, rt;
  logic [1:0]  rs_tuse, rt_tuse;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic        flush;
  logic        stall;
  logic [31:0] busy_vec;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  grf_scoreboard dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_tnew  (issue_tnew),
    .use_rs      (use_rs),
    .rs          (rs),
    .rs_tuse     (rs_tuse),
    .use_rt      (use_rt),
    .rt          (rt),
    .rt_tuse     (rt_tuse),
    .wb_we       (wb_we),
    .wb_a3       (wb_a3),
    .flush       (flush),
    .stall       (stall),
    .busy_vec    (busy_vec),
    .err         (err)
  );

  typedef struct {
    logic        rst, iv, we;
    logic [4:0]  rd;
    logic [1:0]  tnew;
    logic        urs;
    logic [4:0]  rs;
    logic [1:0]  rs_tu;
    logic        urt;
    logic [4:0]  rt;
    logic [1:0]  rt_tu;
    logic        wbwe;
    logic [4:0]  wba;
    logic        fl;
    logic        e_stall;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, iv, we, input logic [4:0] rd, input logic [1:0] tn,
                     input logic urs_i, input logic [4:0] rs_i, input logic [1:0] rstu,
                     input logic urt_i, input logic [4:0] rt_i, input logic [1:0] rttu,
                     input logic wbwe, input logic [4:0] wba, input logic fl,
                     input logic es, input logic [31:0] eb, input logic ee);
    vec_t v;
    v.rst = rst; v.iv = iv; v.we = we; v.rd = rd; v.tnew = tn;
    v.urs = urs_i; v.rs = rs_i; v.rs_tu = rstu;
    v.urt = urt_i; v.rt = rt_i; v.rt_tu = rttu;
    v.wbwe = wbwe; v.wba = wba; v.fl = fl;
    v.e_stall = es; v.e_busy = eb; v.e_err = ee;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; issue_valid = v.iv; issue_we = v.we; issue_rd = v.rd;
    issue_tnew = v.tnew; use_rs = v.urs; rs = v.rs; rs_tuse = v.rs_tu;
    use_rt = v.urt; rt = v.rt; rt_tuse = v.rt_tu;
    wb_we = v.wbwe; wb_a3 = v.wba; flush = v.fl;
  endtask

  initial begin
    vec_t v;
    // reset with random inputs for two cycles; stall must be forced low
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      v.rst = 1'b1; v.iv = 1'b1; v.we = 1'b1;
      v.rd = 5'($urandom_range(31)); v.tnew = 2'($urandom_range(3));
      v.urs = 1'b1; v.rs = 5'($urandom_range(31)); v.rs_tu = 2'd0;
      v.urt = 1'b1; v.rt = 5'($urandom_range(31)); v.rt_tu = 2'd0;
      v.wbwe = 1'($urandom_range(1)); v.wba = 5'($urandom_range(31));
      v.fl = 1'($urandom_range(1));
      drive(v);
      #1 chk("reset_stall", -1, 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("reset_busy", -1, busy_vec, 32'd0);
      chk("reset_err", -1, 32'(err), 32'd0);
    end

    //   rst iv we rd tn  urs rs tu  urt rt tu  wbwe wba fl  stall busy        err
    add(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h0,      0);
    add(0, 1, 1, 8, 2,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h100,    0);
    add(0, 1, 0, 0, 0,  1, 8, 0,  0, 0, 0,  0, 0, 0,  1, 32'h100,    0); // cnt8=2
    add(0, 1, 0, 0, 0,  1, 8, 0,  0, 0, 0,  0, 0, 0,  1, 32'h100,    0); // cnt8=1
    add(0, 1, 0, 0, 0,  1, 8, 0,  0, 0, 0,  0, 0, 0,  0, 32'h100,    0); // cnt8=0
    add(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 8, 0,  0, 32'h0,      0);
    add(0, 1, 1, 0, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h0,      0); // rd=0 ignored
    add(0, 1, 0, 0, 0,  1, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h0,      0);
    add(0, 1, 1, 5, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h20,     0);
    add(0, 1, 1, 5, 3,  0, 0, 0,  0, 0, 0,  1, 5, 0,  0, 32'h20,     0); // issue+retire
    add(0, 1, 0, 0, 0,  1, 5, 2,  0, 0, 0,  0, 0, 0,  1, 32'h20,     0); // cnt5=3
    add(0, 1, 0, 0, 0,  1, 5, 2,  1, 5, 1,  0, 0, 0,  1, 32'h20,     0); // cnt5=2, rt blocks
    add(0, 1, 0, 0, 0,  1, 8, 0,  1, 5, 1,  0, 0, 0,  0, 32'h20,     0); // cnt5=1
    add(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 5, 0,  0, 32'h0,      0);
    add(0, 1, 1, 9, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h200,    0);
    add(0, 1, 1, 9, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h200,    0);
    add(0, 1, 1, 9, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h200,    0);
    add(0, 1, 1, 9, 1,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h200,    1); // 4th writer
    add(1, 1, 1,10, 2,  1, 9, 0,  0, 0, 0,  1, 9, 0,  0, 32'h0,      0); // mid-run reset
    add(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h0,      0);
    add(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  1, 3, 0,  0, 32'h0,      1); // idle retire
    add(0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h0,      1); // sticky
    add(1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h0,      0);
    add(0, 1, 1, 2, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h4,      0);
    add(0, 1, 1, 4, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h14,     0);
    add(0, 1, 1, 6, 3,  0, 0, 0,  0, 0, 0,  0, 0, 0,  0, 32'h54,     0);
    add(0, 1, 0, 0, 0,  1, 4, 1,  0, 0, 0,  0, 0, 0,  1, 32'h54,     0); // cnt4=2
    add(0, 1, 1, 7, 3,  0, 0, 0,  0, 0, 0,  0, 0, 1,  0, 32'h0,      0); // flush wins
    add(0, 1, 0, 0, 0,  1, 2, 0,  1, 7, 0,  0, 0, 0,  0, 32'h0,      0);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1 chk("stall", i, 32'(stall), 32'(vq[i].e_stall));
      @(posedge clk); #1;
      chk("busy_vec", i, busy_vec, vq[i].e_busy);
      chk("err", i, 32'(err), 32'(vq[i].e_err));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
